// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the FSM state encoding, the hard-wired zero register index and the
// default data/address widths shared with write_back_mux and the register file.
package wb_port_arbiter_pkg;

  // Default widths used across the writeback path.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Register 0 is hard-wired to zero; writes to it are granted but dropped.
  localparam int REG_ZERO = 0;

  // Auxiliary write queue depth. The FIFO uses 1-bit pointers, so this is fixed at 2.
  localparam int FIFO_DEPTH = 2;

  // Wide enough for a STARVE_LIMIT of up to 15.
  typedef logic [3:0] starve_cnt_t;

  // Arbiter states: NORMAL gives the WB stage priority; FORCE is a single
  // stalled cycle in which the oldest aux write is retired.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  // WB stage result select: load data or ALU result.
  function automatic logic [DEF_DATA_W-1:0] wb_select(
    input logic                  memtoreg,
    input logic [DEF_DATA_W-1:0] mem_data,
    input logic [DEF_DATA_W-1:0] alu_result
  );
    return memtoreg ? mem_data : alu_result;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/aux unit and the write-port arbiter.
// The slave modport is the arbiter's view; master is the requester/observer side.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // WB stage request
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_mem_data;
  logic [DATA_W-1:0] pipe_alu_result;
  logic              pipe_memtoreg;

  // Aux (mult/div) result handshake
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_rd;
  logic [DATA_W-1:0] aux_data;

  // Registered results
  logic              pipe_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  pipe_we, pipe_rd, pipe_mem_data, pipe_alu_result, pipe_memtoreg,
    input  aux_valid, aux_rd, aux_data,
    output aux_ready,
    output pipe_stall, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_we, pipe_rd, pipe_mem_data, pipe_alu_result, pipe_memtoreg,
    output aux_valid, aux_rd, aux_data,
    input  aux_ready,
    input  pipe_stall, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_port_arbiter_aux_fifo.sv
// Two-entry queue for aux register writes waiting on the write port.
// Push is ignored when full, pop is ignored when empty; both may happen in one
// cycle. Head outputs show the oldest entry; a new entry becomes visible at the
// head only after the edge that pushed it.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_head_rd,
  output logic [DATA_W-1:0] o_head_data
);

  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_mem_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_rd   = r_mem_rd[r_rd_ptr];
  assign o_head_data = r_mem_data[r_rd_ptr];

  // Pointer and occupancy update; 1-bit pointers wrap modulo 2 on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      // Capture the pushed write into the slot the write pointer names.
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_mem_rd[gi]   <= i_rd;
          r_mem_data[gi] <= i_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the MIPS pipeline.
// The WB stage has priority; aux (mult/div) results queue in a 2-entry FIFO.
// If the FIFO head is blocked for STARVE_LIMIT consecutive cycles, the arbiter
// spends one cycle in FORCE, stalling the pipeline and retiring the head.
// Optional build macro: WB_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 4           // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef WB_CONFLICT_CNT_EN
  output logic [15:0] conflict_cnt,
`endif
  wb_port_arbiter_if.slave bus
);

  localparam starve_cnt_t STARVE_MAX = starve_cnt_t'(STARVE_LIMIT - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  starve_cnt_t       r_starve_cnt;
  starve_cnt_t       w_starve_next;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_rd;
  logic [DATA_W-1:0] w_head_data;

  logic              w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic [DATA_W-1:0] w_pipe_data;

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_pipe_stall;

  // Aux handshake: readiness depends on FIFO occupancy only.
  assign bus.aux_ready = !w_fifo_full;
  assign w_push        = bus.aux_valid && !w_fifo_full;

  assign w_pipe_data = DATA_W'(wb_select(bus.pipe_memtoreg,
                                         DEF_DATA_W'(bus.pipe_mem_data),
                                         DEF_DATA_W'(bus.pipe_alu_result)));

  wb_aux_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_aux_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_rd        (bus.aux_rd),
    .i_data      (bus.aux_data),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data)
  );

  // Arbitration: pick this cycle's writer, pop decision and starvation tracking.
  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    w_grant       = 1'b0;
    w_pop         = 1'b0;
    w_gnt_addr    = r_rf_waddr;
    w_gnt_data    = r_rf_wdata;

    case (r_state)
      ST_NORMAL: begin
        if (bus.pipe_we) begin
          w_grant    = 1'b1;
          w_gnt_addr = bus.pipe_rd;
          w_gnt_data = w_pipe_data;
          if (!w_fifo_empty) begin
            // Head is blocked by the pipe; the blocked cycle that reaches the
            // limit arms the forced grant for the following cycle.
            if (r_starve_cnt == STARVE_MAX) w_state_next = ST_FORCE;
            w_starve_next = r_starve_cnt + starve_cnt_t'(1);
          end else begin
            w_starve_next = '0;
          end
        end else if (!w_fifo_empty) begin
          w_grant       = 1'b1;
          w_pop         = 1'b1;
          w_gnt_addr    = w_head_rd;
          w_gnt_data    = w_head_data;
          w_starve_next = '0;
        end else begin
          w_starve_next = '0;
        end
      end

      ST_FORCE: begin
        // Pipeline is stalled this cycle and will re-present its write.
        if (!w_fifo_empty) begin
          w_grant    = 1'b1;
          w_pop      = 1'b1;
          w_gnt_addr = w_head_rd;
          w_gnt_data = w_head_data;
        end
        w_starve_next = '0;
        w_state_next  = ST_NORMAL;
      end

      default: begin
        w_state_next  = ST_NORMAL;
        w_starve_next = '0;
      end
    endcase
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // Registered write port and stall: the grant shows up one clock later;
  // writes to the zero register are granted but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      r_rf_we      <= w_grant && (w_gnt_addr != ADDR_W'(REG_ZERO));
      r_pipe_stall <= (w_state_next == ST_FORCE);
      if (w_grant) begin
        r_rf_waddr <= w_gnt_addr;
        r_rf_wdata <= w_gnt_data;
      end
    end
  end

  assign bus.rf_we      = r_rf_we;
  assign bus.rf_waddr   = r_rf_waddr;
  assign bus.rf_wdata   = r_rf_wdata;
  assign bus.pipe_stall = r_pipe_stall;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  // Count cycles in which the pipe wants the port while aux writes wait; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'd0;
    end else if (bus.pipe_we && !w_fifo_empty && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  // Conflict counter is not built in this configuration.
`endif

endmodule
